// File: rtl/spn_round_engine.sv
// rtl/spn_round_engine.sv - iterative 16-bit SPN cipher core, one round per clock
package spn_pkg;

    function automatic logic [3:0] sbox4(input logic [3:0] n);
        logic [3:0] r;
        case (n)
            4'h0: r = 4'hC;
            4'h1: r = 4'h5;
            4'h2: r = 4'h6;
            4'h3: r = 4'hB;
            4'h4: r = 4'h9;
            4'h5: r = 4'h0;
            4'h6: r = 4'hA;
            4'h7: r = 4'hD;
            4'h8: r = 4'h3;
            4'h9: r = 4'hE;
            4'hA: r = 4'hF;
            4'hB: r = 4'h8;
            4'hC: r = 4'h4;
            4'hD: r = 4'h7;
            4'hE: r = 4'h1;
            default: r = 4'h2;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] sbox_layer16(input logic [15:0] s);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = sbox4(s[4*i +: 4]);
        end
        return r;
    endfunction

    // Bit i -> (4*i) mod 15, bit 15 fixed: equivalent to a 4x4 bit-matrix transpose.
    function automatic logic [15:0] perm16(input logic [15:0] s);
        return {s[15], s[11], s[7], s[3],
                s[14], s[10], s[6], s[2],
                s[13], s[9],  s[5], s[1],
                s[12], s[8],  s[4], s[0]};
    endfunction

endpackage

module spn_round_engine
    import spn_pkg::*;
#(
    parameter int NUM_ROUNDS = 4,
    parameter int WIDTH      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic [3:0]       round_o
);

    if (WIDTH != 16) begin : g_width_chk
        $error("spn_round_engine: WIDTH must be 16");
    end
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 15) begin : g_rounds_chk
        $error("spn_round_engine: NUM_ROUNDS must be in 1..15");
    end

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

    fsm_t             fsm_q;
    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] rk_q;
    logic [3:0]       round_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] rk_d;

    always_comb begin
        state_d = perm16(sbox_layer16(state_q ^ rk_q));
        rk_d    = {rk_q[12:0], rk_q[15:13]} ^ {12'b0, round_q + 4'd1};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q       <= S_IDLE;
            state_q     <= '0;
            rk_q        <= '0;
            round_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (in_valid) begin
                        fsm_q      <= S_RUN;
                        state_q    <= in_data;
                        rk_q       <= in_key;
                        round_q    <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_RUN: begin
                    state_q <= state_d;
                    rk_q    <= rk_d;
                    round_q <= round_q + 4'd1;
                    if (round_q == LAST_ROUND) begin
                        fsm_q       <= S_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    // Everything stays frozen until the consumer takes the block.
                    if (out_ready) begin
                        fsm_q       <= S_IDLE;
                        round_q     <= '0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    fsm_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = state_q;
    assign busy      = busy_q;
    assign round_o   = round_q;

endmodule

// File: tb/tb_spn_round_engine.sv
// tb/tb_spn_round_engine.sv - self-checking bench for spn_round_engine (1, 2 and 4 rounds)
module tb_spn_round_engine;

    localparam int NI = 3;
    localparam int SB[16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [NI];
    logic        in_ready  [NI];
    logic        out_valid [NI];
    logic        out_ready [NI];
    logic        busy      [NI];
    logic [15:0] in_data   [NI];
    logic [15:0] in_key    [NI];
    logic [15:0] out_data  [NI];
    logic [3:0]  round_o   [NI];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        spn_round_engine #(
            .NUM_ROUNDS((g == 0) ? 1 : ((g == 1) ? 2 : 4)),
            .WIDTH     (16)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data[g]),
            .in_key   (in_key[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data (out_data[g]),
            .busy     (busy[g]),
            .round_o  (round_o[g])
        );
    end

    function automatic int nr_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    function automatic logic [15:0] ref_cipher(input logic [15:0] d, input logic [15:0] key, input int nr);
        int s, rk, x, y, p;
        s  = int'(d);
        rk = int'(key);
        for (int r = 0; r < nr; r++) begin
            x = s ^ rk;
            y = 0;
            for (int i = 0; i < 4; i++) y = y | (SB[(x >> (4 * i)) & 15] << (4 * i));
            p = 0;
            for (int i = 0; i < 16; i++) begin
                if (((y >> i) & 1) != 0) p = p | (1 << ((i == 15) ? 15 : ((4 * i) % 15)));
            end
            s  = p;
            rk = (((rk << 3) | (rk >> 13)) & 'hFFFF) ^ ((r + 1) % 16);
        end
        return s[15:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            in_data[k]   = '0;
            in_key[k]    = '0;
        end
        repeat (2) tick();
        for (int k = 0; k < NI; k++) begin
            n_checks++;
            if (in_ready[k] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready[%0d]: got %b want 1", k, in_ready[k]); end
            n_checks++;
            if (out_valid[k] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid[%0d]: got %b want 0", k, out_valid[k]); end
            n_checks++;
            if (busy[k] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b want 0", k, busy[k]); end
            n_checks++;
            if (round_o[k] !== 4'd0) begin n_fail++; $display("FAIL reset_round[%0d]: got %0d want 0", k, round_o[k]); end
            n_checks++;
            if (out_data[k] !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data[%0d]: got %h want 0000", k, out_data[k]); end
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic do_block(input int k, input logic [15:0] d, input logic [15:0] key,
                            input logic [15:0] exp, input string name);
        int w;
        int n;
        int nr;
        nr = nr_of(k);
        out_ready[k] = 1'b1;
        in_data[k]   = d;
        in_key[k]    = key;
        in_valid[k]  = 1'b1;
        w = 0;
        while (!in_ready[k] && w < 50) begin tick(); w++; end
        n_checks++;
        if (in_ready[k] !== 1'b1) begin n_fail++; $display("FAIL %s accept_timeout: in_ready=%b want 1", name, in_ready[k]); end
        tick();
        in_valid[k] = 1'b0;
        n_checks++;
        if (busy[k] !== 1'b1) begin n_fail++; $display("FAIL %s busy_run: got %b want 1", name, busy[k]); end
        n_checks++;
        if (round_o[k] !== 4'd0) begin n_fail++; $display("FAIL %s round_start: got %0d want 0", name, round_o[k]); end
        n = 0;
        while (!out_valid[k] && n < 40) begin
            tick();
            n++;
            if (n <= nr) begin
                n_checks++;
                if (round_o[k] !== 4'(n)) begin n_fail++; $display("FAIL %s round_trace: got %0d want %0d", name, round_o[k], n); end
            end
        end
        n_checks++;
        if (n != nr) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", name, n, nr); end
        n_checks++;
        if (out_data[k] !== exp) begin n_fail++; $display("FAIL %s out_data: got %h want %h", name, out_data[k], exp); end
        tick();
        n_checks++;
        if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
            n_fail++; $display("FAIL %s handoff: out_valid=%b in_ready=%b want 0/1", name, out_valid[k], in_ready[k]);
        end
    endtask

    task automatic test_directed;
        do_block(0, 16'h0000, 16'h0000, 16'hFF00, "r1_zero");
        do_block(0, 16'hFFFF, 16'h0000, 16'h00F0, "r1_data_ones");
        do_block(0, 16'h0000, 16'hFFFF, 16'h00F0, "r1_key_ones");
        do_block(1, 16'h0000, 16'h0000, 16'h23C1, "r2_zero");
    endtask

    task automatic test_random;
        logic [15:0] d, key;
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 8; i++) begin
                d   = 16'($urandom);
                key = 16'($urandom);
                do_block(k, d, key, ref_cipher(d, key, nr_of(k)), "random");
            end
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] d, key, exp;
        int w;
        d   = 16'($urandom);
        key = 16'($urandom);
        exp = ref_cipher(d, key, 4);
        out_ready[2] = 1'b0;
        in_data[2]   = d;
        in_key[2]    = key;
        in_valid[2]  = 1'b1;
        w = 0;
        while (!in_ready[2] && w < 50) begin tick(); w++; end
        tick();
        in_valid[2] = 1'b0;
        repeat (2) tick();
        in_data[2]  = ~d;
        in_key[2]   = ~key;
        in_valid[2] = 1'b1;
        tick();
        in_valid[2] = 1'b0;
        w = 0;
        while (!out_valid[2] && w < 40) begin tick(); w++; end
        n_checks++;
        if (out_valid[2] !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid_timeout: got %b want 1", out_valid[2]); end
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (out_data[2] !== exp) begin n_fail++; $display("FAIL bp_hold_data cycle %0d: got %h want %h", c, out_data[2], exp); end
            n_checks++;
            if (in_ready[2] !== 1'b0 || out_valid[2] !== 1'b1 || round_o[2] !== 4'd4) begin
                n_fail++;
                $display("FAIL bp_hold_ctrl cycle %0d: in_ready=%b out_valid=%b round=%0d want 0/1/4",
                         c, in_ready[2], out_valid[2], round_o[2]);
            end
            tick();
        end
        out_ready[2] = 1'b1;
        tick();
        n_checks++;
        if (out_valid[2] !== 1'b0 || in_ready[2] !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid[2], in_ready[2]);
        end
        repeat (6) tick();
        n_checks++;
        if (out_valid[2] !== 1'b0 || busy[2] !== 1'b0) begin
            n_fail++; $display("FAIL bp_ignored_pulse: out_valid=%b busy=%b want 0/0", out_valid[2], busy[2]);
        end
    endtask

    task automatic test_reset_mid_run;
        int w;
        in_data[2]   = 16'($urandom);
        in_key[2]    = 16'($urandom);
        out_ready[2] = 1'b1;
        in_valid[2]  = 1'b1;
        w = 0;
        while (!in_ready[2] && w < 50) begin tick(); w++; end
        tick();
        in_valid[2] = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (round_o[2] !== 4'd2) begin n_fail++; $display("FAIL mid_reset_pre_round: got %0d want 2", round_o[2]); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (in_ready[2] !== 1'b1 || out_valid[2] !== 1'b0 || round_o[2] !== 4'd0 || busy[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_ctrl: in_ready=%b out_valid=%b round=%0d busy=%b want 1/0/0/0",
                     in_ready[2], out_valid[2], round_o[2], busy[2]);
        end
        n_checks++;
        if (out_data[2] !== 16'h0000) begin n_fail++; $display("FAIL mid_reset_data: got %h want 0000", out_data[2]); end
        do_block(0, 16'h0000, 16'h0000, 16'hFF00, "post_reset");
        n_checks++;
        if (out_valid[2] !== 1'b0) begin n_fail++; $display("FAIL mid_reset_discard: out_valid=%b want 0", out_valid[2]); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] bd [3];
        logic [15:0] bk [3];
        logic [15:0] expq [$];
        logic [15:0] e;
        int acc [3];
        int idx, got, cyc;
        for (int i = 0; i < 3; i++) begin
            bd[i]  = 16'($urandom);
            bk[i]  = 16'($urandom);
            acc[i] = 0;
        end
        idx = 0; got = 0; cyc = 0;
        out_ready[2] = 1'b1;
        in_valid[2]  = 1'b1;
        while (got < 3 && cyc < 200) begin
            if (idx < 3) begin
                in_data[2] = bd[idx];
                in_key[2]  = bk[idx];
            end else begin
                in_valid[2] = 1'b0;
            end
            if (out_valid[2]) begin
                n_checks++;
                if (expq.size() == 0) begin
                    n_fail++; $display("FAIL b2b_unexpected_output: got %h want none", out_data[2]);
                end else begin
                    e = expq.pop_front();
                    if (out_data[2] !== e) begin n_fail++; $display("FAIL b2b_out_data %0d: got %h want %h", got, out_data[2], e); end
                end
                got++;
            end
            if (in_ready[2] && in_valid[2]) begin
                acc[idx] = cyc;
                expq.push_back(ref_cipher(bd[idx], bk[idx], 4));
                idx++;
            end
            tick();
            cyc++;
        end
        in_valid[2] = 1'b0;
        n_checks++;
        if (idx != 3 || got != 3) begin n_fail++; $display("FAIL b2b_count: accepts=%0d outputs=%0d want 3/3", idx, got); end
        for (int i = 1; i < 3; i++) begin
            n_checks++;
            if (acc[i] - acc[i-1] != 6) begin
                n_fail++; $display("FAIL b2b_spacing %0d: got %0d want 6", i, acc[i] - acc[i-1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
